// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encodings and active-low strobe levels for the A09 fetch path
package fetch_unit_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;
  localparam logic ASSERTED_N   = 1'b0;
  localparam logic DEASSERTED_N = 1'b1;
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter with branch load (priority) and wrap-around increment
module fetch_pc #(
  parameter int AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 load,
  input  logic                 inc,
  input  logic [AddrWidth-1:0] load_value,
  output logic [AddrWidth-1:0] pc
);
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) pc <= '0;
    else if (load) pc <= load_value;
    else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: A09 instruction-fetch sequencer; reads memory at PC and loads the word into the IR
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DataWidth     = 16,
  parameter int AddrWidth     = 16,
  parameter int TimeoutCycles = 15
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 start_ni,
  input  logic                 branch_ni,
  input  logic [AddrWidth-1:0] branch_addr_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_rd_no,
  input  logic                 mem_rdy_i,
  input  logic [DataWidth-1:0] mem_data_i,
  output logic [DataWidth-1:0] ir_data_o,
  output logic                 ir_ld_no,
  output logic [AddrWidth-1:0] pc_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fault_o
);
  localparam int CntW = $clog2(TimeoutCycles + 1);
  state_t              state;
  logic [CntW-1:0]     cnt;
  logic [DataWidth-1:0] ir;
  logic [AddrWidth-1:0] pc;
  fetch_pc #(.AddrWidth(AddrWidth)) u_pc (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .load       (state == ST_IDLE && branch_ni == ASSERTED_N),
    .inc        (state == ST_LOAD),
    .load_value (branch_addr_i),
    .pc         (pc)
  );
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ir    <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (branch_ni != ASSERTED_N && start_ni == ASSERTED_N) state <= ST_REQ;
        ST_REQ: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT:
          if (mem_rdy_i) begin
            ir    <= mem_data_i;
            state <= ST_LOAD;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CntW'(TimeoutCycles - 1)) state <= ST_FAULT;
          end
        ST_LOAD:  state <= ST_IDLE;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  // Every strobe is a pure decode of the state register, so no input reaches an output.
  assign mem_addr_o = pc;
  assign pc_o       = pc;
  assign ir_data_o  = ir;
  assign mem_rd_no  = (state == ST_REQ || state == ST_WAIT) ? ASSERTED_N : DEASSERTED_N;
  assign ir_ld_no   = (state == ST_LOAD) ? ASSERTED_N : DEASSERTED_N;
  assign busy_o     = state == ST_REQ || state == ST_WAIT || state == ST_LOAD;
  assign done_o     = state == ST_LOAD;
  assign fault_o    = state == ST_FAULT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven checks of fetch_unit plus timeout and async-reset sequences
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_ni = 1'b1;
  logic        branch_ni = 1'b1;
  logic [15:0] branch_addr_i = '0;
  logic [15:0] mem_addr_o;
  logic        mem_rd_no;
  logic        mem_rdy_i = 1'b0;
  logic [15:0] mem_data_i = '0;
  logic [15:0] ir_data_o;
  logic        ir_ld_no;
  logic [15:0] pc_o;
  logic        busy_o;
  logic        done_o;
  logic        fault_o;
  int pass_cnt = 0;
  int total = 0;

  fetch_unit dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_ni(start_ni), .branch_ni(branch_ni),
    .branch_addr_i(branch_addr_i), .mem_addr_o(mem_addr_o), .mem_rd_no(mem_rd_no),
    .mem_rdy_i(mem_rdy_i), .mem_data_i(mem_data_i), .ir_data_o(ir_data_o),
    .ir_ld_no(ir_ld_no), .pc_o(pc_o), .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start_n, branch_n;
    logic [15:0] baddr;
    logic        rdy;
    logic [15:0] data;
    logic        rd_n, ld_n, busy, done;
    logic [15:0] addr, pc, ir;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [63:0] outs();
    return {12'd0, mem_rd_no, ir_ld_no, busy_o, done_o, mem_addr_o, pc_o, ir_data_o};
  endfunction

  initial begin
    int first;
    tbl[0]  = '{0, 1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{1, 1, 16'h0000, 1, 16'hDEAD, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[2]  = '{1, 1, 16'h0000, 1, 16'h00A0, 1, 0, 1, 1, 16'h0000, 16'h0000, 16'h00A0};
    tbl[3]  = '{1, 1, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 16'h0001, 16'h0001, 16'h00A0};
    tbl[4]  = '{1, 0, 16'hFFFF, 0, 16'h0000, 1, 1, 0, 0, 16'hFFFF, 16'hFFFF, 16'h00A0};
    tbl[5]  = '{0, 1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 16'h00A0};
    tbl[6]  = '{1, 1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 16'h00A0};
    tbl[7]  = '{1, 1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 16'h00A0};
    tbl[8]  = '{0, 0, 16'h7777, 0, 16'h0000, 0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 16'h00A0};
    tbl[9]  = '{1, 1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 16'h00A0};
    tbl[10] = '{1, 1, 16'h0000, 1, 16'h1234, 1, 0, 1, 1, 16'hFFFF, 16'hFFFF, 16'h1234};
    tbl[11] = '{1, 1, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h1234};
    tbl[12] = '{0, 0, 16'h0040, 0, 16'h0000, 1, 1, 0, 0, 16'h0040, 16'h0040, 16'h1234};
    tbl[13] = '{0, 1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 16'h0040, 16'h0040, 16'h1234};
    tbl[14] = '{1, 1, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 16'h0040, 16'h0040, 16'h1234};
    tbl[15] = '{1, 1, 16'h0000, 1, 16'hBEEF, 1, 0, 1, 1, 16'h0040, 16'h0040, 16'hBEEF};
    tbl[16] = '{1, 1, 16'h0000, 0, 16'h0000, 1, 1, 0, 0, 16'h0041, 16'h0041, 16'hBEEF};

    // reset state
    @(posedge clk); #1;
    check("reset_outs", {fault_o, outs()}, {1'b0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 48'h0});
    @(negedge clk) reset_ni = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start_ni = tbl[i].start_n; branch_ni = tbl[i].branch_n; branch_addr_i = tbl[i].baddr;
      mem_rdy_i = tbl[i].rdy; mem_data_i = tbl[i].data;
      @(posedge clk); #1;
      check($sformatf("row%0d", i), outs(),
            {12'd0, tbl[i].rd_n, tbl[i].ld_n, tbl[i].busy, tbl[i].done, tbl[i].addr, tbl[i].pc, tbl[i].ir});
    end

    // timeout: fault appears 16 edges after the start edge (1 REQ + 15 WAIT)
    @(negedge clk) begin start_ni = 1'b0; mem_rdy_i = 1'b0; end
    @(posedge clk); #1;
    @(negedge clk) start_ni = 1'b1;
    first = 0;
    for (int n = 1; n <= 40 && first == 0; n++) begin
      @(posedge clk); #1;
      if (n == 15) check("wait_before_fault", {fault_o, mem_rd_no}, 2'b00);
      if (fault_o) first = n;
    end
    check("timeout_edges", first, 16);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) start_ni = 1'b0;
      @(posedge clk); #1;
      check("fault_sticky", {fault_o, mem_rd_no, ir_ld_no, busy_o, done_o, pc_o},
            {5'b11100, 16'h0041});
    end
    @(negedge clk) start_ni = 1'b1;
    #2 reset_ni = 1'b0;
    #1 check("fault_cleared", {fault_o, busy_o, mem_rd_no, pc_o, ir_data_o}, {3'b001, 32'h0});
    @(negedge clk) reset_ni = 1'b1;

    // reset mid-fetch from pc 0x0005
    @(negedge clk) begin branch_ni = 1'b0; branch_addr_i = 16'h0005; end
    @(negedge clk) begin branch_ni = 1'b1; start_ni = 1'b0; end
    @(negedge clk) start_ni = 1'b1;
    @(negedge clk);
    check("mid_wait", {mem_rd_no, busy_o, mem_addr_o}, {2'b01, 16'h0005});
    #2 reset_ni = 1'b0;
    #1 check("async_reset", {mem_rd_no, ir_ld_no, busy_o, done_o, fault_o, pc_o}, {5'b11000, 16'h0000});
    mem_rdy_i = 1'b1; mem_data_i = 16'hCAFE;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("no_ld_in_reset", {ir_ld_no, done_o, ir_data_o}, {2'b10, 16'h0000});
    end
    @(negedge clk) begin reset_ni = 1'b1; mem_rdy_i = 1'b0; end
    @(posedge clk); #1;
    check("post_reset_idle", {mem_rd_no, ir_ld_no, busy_o, pc_o, ir_data_o}, {3'b110, 32'h0});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
